// File: rtl/filter_select_seq.sv
`timescale 1ns/1ps
// Band-pass relay selector: three-stage frequency-to-band pipeline with hysteresis,
// followed by a break-before-make relay sequencer that gates the exciter.
module filter_select_seq #(
    parameter int unsigned N_FILT     = 7,
    parameter int unsigned FREQ_W     = 32,
    parameter int unsigned HYST       = 50000,
    parameter int unsigned DEAD_CYC   = 8,
    parameter int unsigned SETTLE_CYC = 16
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [FREQ_W-1:0] frequency,
    input  logic              ptt,
    input  logic              thr_wr,
    input  logic [3:0]        thr_addr,
    input  logic [FREQ_W-1:0] thr_data,
    input  logic              man_en,
    input  logic [3:0]        man_idx,
    output logic [N_FILT-1:0] lpf,
    output logic [3:0]        band_idx,
    output logic              busy,
    output logic              tx_inhibit
);

    localparam int unsigned CNT_MAX = (DEAD_CYC > SETTLE_CYC) ? DEAD_CYC : SETTLE_CYC;
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [3:0]        LAST_IDX    = 4'(N_FILT - 1);
    localparam logic [3:0]        MAX_THR     = 4'(N_FILT - 2);
    localparam logic [FREQ_W:0]   HYST_EXT    = (FREQ_W + 1)'(HYST);
    localparam logic [CNT_W-1:0]  DEAD_LOAD   = CNT_W'(DEAD_CYC - 1);
    localparam logic [CNT_W-1:0]  SETTLE_LOAD = CNT_W'(SETTLE_CYC - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BREAK,
        ST_MAKE
    } state_t;

    // Table is sized to the full 4-bit index space; unused upper entries stay all-ones.
    logic [FREQ_W-1:0] thr [16];

    logic [FREQ_W-1:0] f_q;
    logic              man_en_q;
    logic [3:0]        man_idx_q;

    logic [3:0]        cand_c;
    logic [3:0]        cand_q;
    logic [FREQ_W-1:0] f2_q;
    logic              man_q;

    logic [FREQ_W:0]   up_lim;
    logic [FREQ_W:0]   dn_sum;
    logic [FREQ_W-1:0] thr_dn;
    logic [3:0]        want_c;
    logic [3:0]        want_q;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [3:0]        tgt_q, tgt_d;
    logic [3:0]        band_q, band_d;
    logic [N_FILT-1:0] lpf_q, lpf_d;
    logic              busy_q, busy_d;

    function automatic logic [N_FILT-1:0] onehot(input logic [3:0] idx);
        logic [N_FILT-1:0] res;
        res = '0;
        for (int unsigned i = 0; i < N_FILT; i++) begin
            if (4'(i) == idx) res[i] = 1'b1;
        end
        return res;
    endfunction

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < 16; i++) thr[i] <= '1;
        end else if (thr_wr && (thr_addr <= MAX_THR)) begin
            thr[thr_addr] <= thr_data;
        end
    end

    // Manual controls ride stage 1 with frequency so both paths share the same latency.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            f_q       <= '0;
            man_en_q  <= 1'b0;
            man_idx_q <= '0;
        end else begin
            f_q       <= frequency;
            man_en_q  <= man_en;
            man_idx_q <= man_idx;
        end
    end

    always_comb begin
        cand_c = '0;
        for (int unsigned i = 0; i < N_FILT - 1; i++) begin
            if (f_q > thr[4'(i)]) cand_c = cand_c + 4'd1;
        end
        if (man_en_q) cand_c = (man_idx_q > LAST_IDX) ? LAST_IDX : man_idx_q;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cand_q <= '0;
            f2_q   <= '0;
            man_q  <= 1'b0;
        end else begin
            cand_q <= cand_c;
            f2_q   <= f_q;
            man_q  <= man_en_q;
        end
    end

    // thr_dn wraps to an all-ones entry when band_q is 0; it is only consulted when band_q >= 1.
    always_comb begin
        up_lim = {1'b0, thr[band_q]} + HYST_EXT;
        dn_sum = {1'b0, f2_q} + HYST_EXT;
        thr_dn = thr[band_q - 4'd1];
        want_c = band_q;
        if (man_q) begin
            want_c = cand_q;
        end else if (cand_q > band_q) begin
            if ({1'b0, f2_q} > up_lim) want_c = cand_q;
        end else if (cand_q < band_q) begin
            if (dn_sum <= {1'b0, thr_dn}) want_c = cand_q;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) want_q <= '0;
        else          want_q <= want_c;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tgt_d   = tgt_q;
        band_d  = band_q;
        lpf_d   = lpf_q;
        case (state_q)
            ST_IDLE: begin
                lpf_d = onehot(band_q);
                if ((want_q != band_q) && !ptt) begin
                    state_d = ST_BREAK;
                    tgt_d   = want_q;
                    cnt_d   = DEAD_LOAD;
                    lpf_d   = '0;
                end
            end
            ST_BREAK: begin
                if (cnt_q == '0) begin
                    state_d = ST_MAKE;
                    cnt_d   = SETTLE_LOAD;
                    band_d  = tgt_q;
                    lpf_d   = onehot(tgt_q);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_MAKE: begin
                if (cnt_q == '0) state_d = ST_IDLE;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            tgt_q   <= '0;
            band_q  <= '0;
            lpf_q   <= N_FILT'(1);
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tgt_q   <= tgt_d;
            band_q  <= band_d;
            lpf_q   <= lpf_d;
            busy_q  <= busy_d;
        end
    end

    assign lpf        = lpf_q;
    assign band_idx   = band_q;
    assign busy       = busy_q;
    assign tx_inhibit = busy_q;

endmodule

// File: tb/tb_filter_select_seq.sv
`timescale 1ns/1ps
// Scoreboard bench for filter_select_seq: stimulus queues expected relay sequences,
// a negedge monitor measures each sequence and checks it against the queue.
module tb_filter_select_seq;

    localparam int unsigned NF     = 7;
    localparam int unsigned FW     = 32;
    localparam int unsigned DEAD   = 8;
    localparam int unsigned SETTLE = 16;

    logic          clock = 1'b0;
    logic          reset_n = 1'b1;
    logic [FW-1:0] frequency = '0;
    logic          ptt = 1'b0;
    logic          thr_wr = 1'b0;
    logic [3:0]    thr_addr = '0;
    logic [FW-1:0] thr_data = '0;
    logic          man_en = 1'b0;
    logic [3:0]    man_idx = '0;
    logic [NF-1:0] lpf;
    logic [3:0]    band_idx;
    logic          busy;
    logic          tx_inhibit;

    filter_select_seq #(
        .N_FILT(NF), .FREQ_W(FW), .HYST(50000), .DEAD_CYC(DEAD), .SETTLE_CYC(SETTLE)
    ) dut (
        .clock(clock), .reset_n(reset_n), .frequency(frequency), .ptt(ptt),
        .thr_wr(thr_wr), .thr_addr(thr_addr), .thr_data(thr_data),
        .man_en(man_en), .man_idx(man_idx), .lpf(lpf), .band_idx(band_idx),
        .busy(busy), .tx_inhibit(tx_inhibit)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [3:0] band;
        int         start;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   viol  = 0;
    int   cyc   = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [NF-1:0] exp_lpf(input logic [3:0] b);
        logic [NF-1:0] one;
        one = NF'(1);
        return one << b;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic expect_seq(input logic [3:0] b, input int start);
        exp_t e;
        e.band  = b;
        e.start = start;
        sb.push_back(e);
    endtask

    // Monitor
    logic          prev_busy = 1'b0;
    int            start_cyc, brk, mk;
    logic [NF-1:0] mk_lpf;
    logic [3:0]    mk_band;

    always @(negedge clock) begin
        exp_t e;
        if (!reset_n) begin
            prev_busy = 1'b0;
        end else begin
            if (tx_inhibit !== busy) viol++;
            if (!$onehot0(lpf)) viol++;
            if (busy) begin
                if (!prev_busy) begin
                    start_cyc = cyc;
                    brk = 0;
                    mk  = 0;
                end
                if (lpf == '0) begin
                    brk++;
                    if (mk != 0) viol++;
                end else begin
                    if (mk != 0 && lpf !== mk_lpf) viol++;
                    mk++;
                    mk_lpf  = lpf;
                    mk_band = band_idx;
                end
            end else begin
                if (lpf !== exp_lpf(band_idx)) viol++;
                if (prev_busy) begin
                    if (sb.size() == 0) begin
                        chk("seq_expected", 0, 1);
                    end else begin
                        e = sb.pop_front();
                        if (e.start != 0) chk("break_start", start_cyc, e.start);
                        chk("break_len", brk, DEAD);
                        chk("make_len", mk, SETTLE);
                        chk("make_lpf", mk_lpf, exp_lpf(e.band));
                        chk("make_band", mk_band, e.band);
                        chk("final_band", band_idx, e.band);
                    end
                end
            end
            prev_busy = busy;
        end
    end

    int unsigned tab [6] = '{2400000, 4500000, 8000000, 15000000, 32000000, 54000000};
    int c;

    initial begin
        #1 reset_n = 1'b0;
        #1;
        chk("rst_lpf", lpf, 1);
        chk("rst_band", band_idx, 0);
        chk("rst_busy", busy, 0);
        chk("rst_txinh", tx_inhibit, 0);
        tick(3);
        reset_n = 1'b1;

        // Unprogrammed table: no frequency selects anything but index 0
        frequency = 14000000;
        tick(40);
        chk("unprog_band", band_idx, 0);
        chk("unprog_lpf", lpf, 1);
        frequency = 0;
        tick(5);

        for (int i = 0; i < 6; i++) begin
            thr_wr = 1'b1; thr_addr = 4'(i); thr_data = tab[i];
            tick(1);
        end
        thr_wr = 1'b0;
        tick(3);

        frequency = 7100000; c = cyc; expect_seq(2, c + 4);
        tick(40);
        chk("band_40m", band_idx, 2);

        frequency = 8030000;
        tick(40);
        chk("hyst_up_hold", band_idx, 2);
        frequency = 8060000; c = cyc; expect_seq(3, c + 4);
        tick(40);
        frequency = 7970000;
        tick(40);
        chk("hyst_dn_hold", band_idx, 3);
        frequency = 7940000; c = cyc; expect_seq(2, c + 4);
        tick(40);

        ptt = 1'b1; frequency = 14200000;
        tick(40);
        chk("ptt_hold_band", band_idx, 2);
        chk("ptt_hold_lpf", lpf, 7'b0000100);
        chk("ptt_hold_busy", busy, 0);
        ptt = 1'b0; c = cyc; expect_seq(3, c + 1);
        tick(40);

        // Two frequency changes inside MAKE collapse into one follow-up sequence
        frequency = 7100000; c = cyc; expect_seq(2, c + 4);
        tick(16);
        frequency = 14200000;
        tick(3);
        frequency = 33000000; expect_seq(5, 0);
        tick(70);
        chk("retarget_band", band_idx, 5);

        man_en = 1'b1; man_idx = 15; c = cyc; expect_seq(6, c + 4);
        tick(6);
        ptt = 1'b1;
        tick(34);
        ptt = 1'b0;
        tick(1);
        frequency = 2400000;
        tick(30);
        chk("manual_band", band_idx, 6);
        chk("manual_lpf", lpf, 7'b1000000);
        frequency = 33000000;
        tick(5);
        man_en = 1'b0; c = cyc; expect_seq(5, c + 4);
        tick(40);

        frequency = 7100000;
        tick(6);
        #1;
        chk("pre_rst_busy", busy, 1);
        chk("pre_rst_lpf", lpf, 0);
        reset_n = 1'b0;
        #1;
        chk("async_rst_lpf", lpf, 1);
        chk("async_rst_band", band_idx, 0);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_txinh", tx_inhibit, 0);
        tick(3);
        reset_n = 1'b1;
        frequency = 14000000;
        tick(40);
        chk("post_rst_band", band_idx, 0);
        chk("post_rst_lpf", lpf, 1);

        chk("sb_empty", sb.size(), 0);
        chk("invariants", viol, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/filter_select_seq.md
FILTER_SELECT_SEQ -- requirements
Module: filter_select_seq

Interface
REQ-001 Parameter N_FILT, default 7: number of filter relays; legal range 2..16.
REQ-002 Parameter FREQ_W, default 32: frequency width in Hz.
REQ-003 Parameter HYST, default 50000: hysteresis in Hz applied at band edges.
REQ-004 Parameter DEAD_CYC, default 8: break interval in cycles, all relays off; minimum 1.
REQ-005 Parameter SETTLE_CYC, default 16: relay settle interval in cycles after make; minimum 1.
REQ-006 clock  input  1  single clock; all logic rising-edge.
REQ-007 reset_n  input  1  asynchronous, active-low reset.
REQ-008 frequency  input  FREQ_W  operating frequency in Hz.
REQ-009 ptt  input  1  transmit active; high freezes relay changes.
REQ-010 thr_wr  input  1  threshold write strobe.
REQ-011 thr_addr  input  4  threshold index, 0..N_FILT-2.
REQ-012 thr_data  input  FREQ_W  threshold value in Hz.
REQ-013 man_en  input  1  manual override enable.
REQ-014 man_idx  input  4  manual filter index.
REQ-015 lpf  output  N_FILT  relay drive, one-hot or all-zero.
REQ-016 band_idx  output  4  index of the filter currently driven.
REQ-017 busy  output  1  high while in BREAK or MAKE.
REQ-018 tx_inhibit  output  1  high while in BREAK or MAKE; the exciter blocks RF on it.

Function
REQ-019 Threshold table thr[0..N_FILT-2] SHALL be written on thr_wr when thr_addr <= N_FILT-2; other addresses ignored; writes accepted in any state.
REQ-020 Table SHALL be treated as ascending; no ordering check.
REQ-021 Stage 1 SHALL register frequency into f_q.
REQ-022 Stage 2 SHALL compute cand as the count of i with f_q > thr[i].
- If man_en: cand = min(man_idx, N_FILT-1), hysteresis bypassed.
REQ-023 Hysteresis rule, with cur = band_idx and sums/differences in FREQ_W+1 bits, saturating at 0:
- cand > cur accepted only if f_q > thr[cur] + HYST.
- cand < cur accepted only if f_q + HYST <= thr[cur-1].
- Otherwise target stays cur.
REQ-024 FSM states: IDLE, BREAK, MAKE.
REQ-025 IDLE -> BREAK when target != cur and ptt=0.
- Target latched into tgt on that edge.
- lpf = 0 from the first BREAK cycle.
REQ-026 BREAK SHALL last exactly DEAD_CYC cycles, then enter MAKE with lpf = one-hot(tgt) and band_idx = tgt.
REQ-027 MAKE SHALL last exactly SETTLE_CYC cycles, then return to IDLE.
REQ-028 busy and tx_inhibit SHALL be 1 exactly in BREAK and MAKE.
REQ-029 Latency: frequency sampled at edge N SHALL produce the first BREAK cycle at edge N+3.
REQ-030 Frequency, threshold or manual changes during BREAK/MAKE SHALL NOT alter tgt; re-evaluation occurs in IDLE.
REQ-031 ptt rising during BREAK/MAKE SHALL NOT abort the sequence; it completes normally.
REQ-032 A change pending while ptt=1 SHALL begin BREAK on the first IDLE cycle with ptt=0 after the pipeline delay.
REQ-033 In IDLE, lpf SHALL equal one-hot(band_idx); it SHALL never have more than one bit set.
REQ-034 target == cur SHALL cause no sequence and no output glitch.

Reset
REQ-035 reset_n low SHALL, asynchronously and in any state (mid-sequence included):
- set lpf = 1 (index 0), band_idx = 0, busy = 0, tx_inhibit = 0, state IDLE;
- clear f_q and tgt;
- set all thresholds to all-ones.
REQ-036 After reset release with no threshold writes, cand SHALL be 0 for every frequency.

Verification
REQ-037 Program thr = 2400000, 4500000, 8000000, 15000000, 32000000, 54000000; frequency 7100000 -> lpf 0, then 3 cycles later lpf = 0 for 8 cycles; then lpf = 0000100b and busy for 16 cycles; then idle with band_idx 2.
REQ-038 With band_idx 2, frequency 8030000 -> no sequence; frequency 8060000 -> switch to index 3; frequency back to 7970000 -> no change; frequency 7940000 -> switch to index 2.
REQ-039 ptt = 1, frequency 14200000 -> lpf unchanged while ptt is high; ptt falls -> BREAK starts 1 cycle later (pipeline already settled); final lpf = 0001000b.
REQ-040 man_en = 1, man_idx = 15 -> target index 6, lpf = 1000000b after the sequence, regardless of frequency.
REQ-041 Assert reset_n low during BREAK -> lpf = 0000001b immediately (asynchronous), busy = 0; thresholds read back as all-ones.
REQ-042 Frequency changes twice during MAKE -> the first sequence completes; a single new sequence to the final frequency's band follows.
